axil_csr_bridge: RTL and testbench

AXI4-Lite slave front-end for the CSR/data register file. Converts AXI4-Lite write and read transactions into single-cycle reg_write/reg_read strobes. Captures the register file's registered reg_rdata/access_violation one cycle later and returns them as RDATA plus BRESP/RRESP. Only one register access is outstanding at any time.

---
 rtl/axil_csr_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_axil_csr_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_csr_bridge.sv
// AXI4-Lite slave front-end for the CSR/data register file.
// Turns AXI4-Lite reads and writes into one-cycle reg_write/reg_read strobes.
// It captures the register file's status and read data one cycle after the strobe
// and returns them as BRESP or RRESP/RDATA. Only one access is outstanding at a time.
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*      AXI4-Lite write address, write data and write response
//   s_ar*/s_r*           AXI4-Lite read address and read data/response
//   reg_addr/reg_wdata   register index and write data driven to the register file
//   reg_write/reg_read   one-cycle access strobes
//   reg_rdata            register file read data, valid the cycle after reg_read
//   access_violation     register file status, valid the cycle after a strobe
module axil_csr_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_DW = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [REG_DW-1:0]     s_wdata,
    input  logic [REG_DW/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [REG_DW-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [REG_AW-1:0]     reg_addr,
    output logic [REG_DW-1:0]     reg_wdata,
    output logic                  reg_write,
    output logic                  reg_read,
    input  logic [REG_DW-1:0]     reg_rdata,
    input  logic [1:0]            access_violation
);

    localparam int unsigned STRB_W = REG_DW / 8;
    localparam int unsigned IDX_LO = 2;
    localparam int unsigned IDX_HI = REG_AW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_STB = 3'd1;
    localparam logic [2:0] S_WR_CAP = 3'd2;
    localparam logic [2:0] S_WR_RSP = 3'd3;
    localparam logic [2:0] S_RD_STB = 3'd4;
    localparam logic [2:0] S_RD_CAP = 3'd5;
    localparam logic [2:0] S_RD_RSP = 3'd6;

    logic [2:0]        r_state,     w_state_nxt;
    logic              r_wr_next,   w_wr_next_nxt;
    logic              r_run;
    logic              r_bvalid,    w_bvalid_nxt;
    logic [1:0]        r_bresp,     w_bresp_nxt;
    logic              r_rvalid,    w_rvalid_nxt;
    logic [1:0]        r_rresp,     w_rresp_nxt;
    logic [REG_DW-1:0] r_rdata,     w_rdata_nxt;
    logic [REG_AW-1:0] r_reg_addr,  w_reg_addr_nxt;
    logic [REG_DW-1:0] r_reg_wdata, w_reg_wdata_nxt;
    logic              r_reg_write, w_reg_write_nxt;
    logic              r_reg_read,  w_reg_read_nxt;

    logic w_wr_req;
    logic w_rd_req;
    logic w_idle;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_aw_decerr;
    logic w_ar_decerr;
    logic w_wstrb_bad;

    // Register-file status to AXI response
    function automatic logic [1:0] map_resp(input logic [1:0] av);
        case (av)
            2'b00:   map_resp = RESP_OKAY;
            2'b11:   map_resp = RESP_DECERR;
            default: map_resp = RESP_SLVERR;
        endcase
    endfunction

    // Request detection and round-robin arbitration; r_run holds readies low through reset
    assign w_wr_req    = s_awvalid && s_wvalid;
    assign w_rd_req    = s_arvalid;
    assign w_idle      = r_run && (r_state == S_IDLE);
    assign w_grant_wr  = w_idle && w_wr_req && (!w_rd_req || r_wr_next);
    assign w_grant_rd  = w_idle && w_rd_req && !w_grant_wr;

    // Any address bit above the register window selects DECERR
    assign w_aw_decerr = (s_awaddr >> (REG_AW + 2)) != '0;
    assign w_ar_decerr = (s_araddr >> (REG_AW + 2)) != '0;
    assign w_wstrb_bad = s_wstrb != {STRB_W{1'b1}};

    assign s_awready = w_grant_wr;
    assign s_wready  = w_grant_wr;
    assign s_arready = w_grant_rd;

    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_rvalid  = r_rvalid;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_write = r_reg_write;
    assign reg_read  = r_reg_read;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_next_nxt   = r_wr_next;
        w_bvalid_nxt    = r_bvalid;
        w_bresp_nxt     = r_bresp;
        w_rvalid_nxt    = r_rvalid;
        w_rresp_nxt     = r_rresp;
        w_rdata_nxt     = r_rdata;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_write_nxt = 1'b0;
        w_reg_read_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_grant_wr) begin
                    w_reg_addr_nxt  = s_awaddr[IDX_HI:IDX_LO];
                    w_reg_wdata_nxt = s_wdata;
                    w_wr_next_nxt   = 1'b0;
                    if (w_aw_decerr) begin
                        w_bresp_nxt  = RESP_DECERR;
                        w_bvalid_nxt = 1'b1;
                        w_state_nxt  = S_WR_RSP;
                    end else if (w_wstrb_bad) begin
                        w_bresp_nxt  = RESP_SLVERR;
                        w_bvalid_nxt = 1'b1;
                        w_state_nxt  = S_WR_RSP;
                    end else begin
                        w_reg_write_nxt = 1'b1;
                        w_state_nxt     = S_WR_STB;
                    end
                end else if (w_grant_rd) begin
                    w_reg_addr_nxt = s_araddr[IDX_HI:IDX_LO];
                    w_wr_next_nxt  = 1'b1;
                    if (w_ar_decerr) begin
                        w_rresp_nxt  = RESP_DECERR;
                        w_rdata_nxt  = '0;
                        w_rvalid_nxt = 1'b1;
                        w_state_nxt  = S_RD_RSP;
                    end else begin
                        w_reg_read_nxt = 1'b1;
                        w_state_nxt    = S_RD_STB;
                    end
                end
            end
            S_WR_STB: w_state_nxt = S_WR_CAP;
            S_WR_CAP: begin
                w_bresp_nxt  = map_resp(access_violation);
                w_bvalid_nxt = 1'b1;
                w_state_nxt  = S_WR_RSP;
            end
            S_WR_RSP: begin
                if (s_bready) begin
                    w_bvalid_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_RD_STB: w_state_nxt = S_RD_CAP;
            S_RD_CAP: begin
                w_rresp_nxt  = map_resp(access_violation);
                w_rdata_nxt  = (access_violation == 2'b00) ? reg_rdata : '0;
                w_rvalid_nxt = 1'b1;
                w_state_nxt  = S_RD_RSP;
            end
            S_RD_RSP: begin
                if (s_rready) begin
                    w_rvalid_nxt = 1'b0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_wr_next   <= 1'b1;
            r_run       <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_rvalid    <= 1'b0;
            r_rresp     <= 2'b00;
            r_rdata     <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_write <= 1'b0;
            r_reg_read  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_next   <= w_wr_next_nxt;
            r_run       <= 1'b1;
            r_bvalid    <= w_bvalid_nxt;
            r_bresp     <= w_bresp_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_rresp     <= w_rresp_nxt;
            r_rdata     <= w_rdata_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_reg_read  <= w_reg_read_nxt;
        end
    end

endmodule

// File: tb/tb_axil_csr_bridge.sv
// Directed self-checking bench for axil_csr_bridge.
// A register-file stub returns the programmed status/data only in the cycle after a strobe.
// In every other cycle it returns poison values.
module tb_axil_csr_bridge;

    logic        clk;
    logic        arst_n;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write;
    logic        reg_read;
    logic [31:0] reg_rdata;
    logic [1:0]  access_violation;

    logic [31:0] tb_rdata;
    logic [1:0]  tb_viol;
    int          checks;
    int          failures;

    axil_csr_bridge #(.ADDR_W(32), .REG_DW(32), .REG_AW(4)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .s_awaddr         (s_awaddr),
        .s_awvalid        (s_awvalid),
        .s_awready        (s_awready),
        .s_wdata          (s_wdata),
        .s_wstrb          (s_wstrb),
        .s_wvalid         (s_wvalid),
        .s_wready         (s_wready),
        .s_bresp          (s_bresp),
        .s_bvalid         (s_bvalid),
        .s_bready         (s_bready),
        .s_araddr         (s_araddr),
        .s_arvalid        (s_arvalid),
        .s_arready        (s_arready),
        .s_rdata          (s_rdata),
        .s_rresp          (s_rresp),
        .s_rvalid         (s_rvalid),
        .s_rready         (s_rready),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_write        (reg_write),
        .reg_read         (reg_read),
        .reg_rdata        (reg_rdata),
        .access_violation (access_violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file stub: status/data are valid only in the cycle after a strobe
    always @(posedge clk) begin
        if (reg_write || reg_read) begin
            reg_rdata        <= tb_rdata;
            access_violation <= tb_viol;
        end else begin
            reg_rdata        <= 32'hBAD0_BAD0;
            access_violation <= 2'b11;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes must never overlap
    always @(negedge clk) begin
        if (arst_n) begin
            checks++;
            assert (!(reg_write && reg_read)) else begin
                failures++;
                $error("FAIL strobe_overlap: observed=%0b%0b expected=not both", reg_write, reg_read);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the bridge back in IDLE
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] viol, input logic [1:0] exp_resp,
                            input logic [3:0] exp_idx, input logic predec);
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tb_viol   = viol;
        #1;
        check("wr_awready", 32'(s_awready), 32'd1);
        check("wr_wready", 32'(s_wready), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!predec) begin
            check("wr_strobe", 32'(reg_write), 32'd1);
            check("wr_addr", 32'(reg_addr), 32'(exp_idx));
            check("wr_wdata", reg_wdata, data);
            check("wr_bvalid_n0", 32'(s_bvalid), 32'd0);
            @(posedge clk); #1;
            check("wr_strobe_off", 32'(reg_write), 32'd0);
            check("wr_bvalid_n1", 32'(s_bvalid), 32'd0);
            @(posedge clk); #1;
        end else begin
            check("wr_no_strobe", 32'(reg_write), 32'd0);
        end
        check("wr_bvalid", 32'(s_bvalid), 32'd1);
        check("wr_bresp", 32'(s_bresp), 32'(exp_resp));
        @(posedge clk); #1;
        check("wr_bvalid_hold", 32'(s_bvalid), 32'd1);
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        check("wr_bvalid_drop", 32'(s_bvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rf_data, input logic [1:0] viol,
                           input logic [1:0] exp_resp, input logic [31:0] exp_data,
                           input logic [3:0] exp_idx, input logic predec, input int hold);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        tb_rdata  = rf_data;
        tb_viol   = viol;
        #1;
        check("rd_arready", 32'(s_arready), 32'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        if (!predec) begin
            check("rd_strobe", 32'(reg_read), 32'd1);
            check("rd_addr", 32'(reg_addr), 32'(exp_idx));
            check("rd_rvalid_n0", 32'(s_rvalid), 32'd0);
            @(posedge clk); #1;
            check("rd_strobe_off", 32'(reg_read), 32'd0);
            check("rd_rvalid_n1", 32'(s_rvalid), 32'd0);
            @(posedge clk); #1;
        end else begin
            check("rd_no_strobe", 32'(reg_read), 32'd0);
        end
        check("rd_rvalid", 32'(s_rvalid), 32'd1);
        check("rd_rresp", 32'(s_rresp), 32'(exp_resp));
        check("rd_rdata", s_rdata, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("rd_rvalid_hold", 32'(s_rvalid), 32'd1);
            check("rd_rdata_hold", s_rdata, exp_data);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        check("rd_rvalid_drop", 32'(s_rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        failures  = 0;
        arst_n    = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        tb_rdata  = '0;
        tb_viol   = 2'b00;

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_strobes", 32'({reg_write, reg_read}), 32'd0);
        check("rst_resps", 32'({s_bresp, s_rresp}), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_wdata", reg_wdata, 32'd0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Normal write, normal read with a 5-cycle rready stall
        do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 2'b00, 4'd1, 1'b0);
        do_read(32'h24, 32'h8, 2'b00, 2'b00, 32'h8, 4'd9, 1'b0, 5);
        // Register file violations
        do_write(32'h0C, 32'h1234_5678, 4'hF, 2'b01, 2'b10, 4'd3, 1'b0);
        do_read(32'h10, 32'h55, 2'b11, 2'b11, 32'h0, 4'd4, 1'b0, 1);
        do_read(32'h18, 32'h77, 2'b10, 2'b10, 32'h0, 4'd6, 1'b0, 0);
        // Pre-decode errors
        do_write(32'h100, 32'hCAFE_F00D, 4'hF, 2'b00, 2'b11, 4'd0, 1'b1);
        do_write(32'h08, 32'hAAAA_5555, 4'h3, 2'b00, 2'b10, 4'd2, 1'b1);
        do_read(32'h40, 32'h99, 2'b00, 2'b11, 32'h0, 4'd0, 1'b1, 0);
        // Address bits [1:0] are ignored
        do_write(32'h3F, 32'h0BAD_CAFE, 4'hF, 2'b00, 2'b00, 4'd15, 1'b0);

        // Reset asserted while the write strobe is high
        s_awaddr  = 32'h08;
        s_wdata   = 32'h1111_2222;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tb_viol   = 2'b00;
        @(posedge clk); #1;
        check("mid_strobe", 32'(reg_write), 32'd1);
        s_arvalid = 1'b1;
        arst_n    = 1'b0;
        #1;
        check("mid_rst_write", 32'(reg_write), 32'd0);
        check("mid_rst_bvalid", 32'(s_bvalid), 32'd0);
        check("mid_rst_readies", 32'({s_awready, s_wready, s_arready}), 32'd0);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        #3;
        arst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_post_bvalid", 32'(s_bvalid), 32'd0);
        do_read(32'h08, 32'h1234, 2'b00, 2'b00, 32'h1234, 4'd2, 1'b0, 0);

        // Round-robin with write and read requests held continuously after a fresh reset
        arst_n = 1'b0;
        #2;
        arst_n    = 1'b1;
        s_awaddr  = 32'h10;
        s_wdata   = 32'h0F0F_0F0F;
        s_wstrb   = 4'hF;
        s_araddr  = 32'h14;
        s_bready  = 1'b1;
        s_rready  = 1'b1;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            int c;
            c = 0;
            while (!(s_awready || s_arready) && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
            check("arb_wr_grant", 32'(s_awready), 32'(k % 2 == 0));
            check("arb_rd_grant", 32'(s_arready), 32'(k % 2 == 1));
            @(posedge clk); #1;
            check("arb_strobe", 32'({reg_write, reg_read}), (k % 2 == 0) ? 32'd2 : 32'd1);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("arb_end_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
        s_bready = 1'b0;
        s_rready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
